// File: rtl/seg_bus_scanner_pkg.sv
// Shared types and constants for the segment-bus scanner.
package seg_bus_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ENABLE,
    GAP
  } scan_state_t;

  // Sized for the largest supported bus; users slice off the low N_SRC bits.
  localparam int unsigned          MAX_SRC = 32;
  localparam logic [MAX_SRC-1:0]   ALL_OFF = '1;

endpackage

// File: rtl/seg_bus_scanner_slot_decoder.sv
// Slot index + active flag to one-hot active-low source enables (combinational).
module seg_slot_decoder #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned SW    = 2
) (
  input  logic [SW-1:0]    slot,
  input  logic             active,
  output logic [N_SRC-1:0] oe_n
);

  always_comb begin
    oe_n = '1;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (active && (slot == SW'(i))) oe_n[i] = 1'b0;
    end
  end

endmodule

// File: rtl/seg_bus_scanner.sv
// Time-multiplexed reader for a shared tri-state segment bus: scans sources
// one at a time with break-before-make gaps and captures each into a bank.
module seg_bus_scanner
  import seg_bus_scanner_pkg::*;
#(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned W     = 7,
  parameter int unsigned DWELL = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [W-1:0]             bus_in,
  output logic [N_SRC-1:0]         oe_n,
  output logic [$clog2(N_SRC)-1:0] slot,
  output logic [N_SRC*W-1:0]       cap_data,
  output logic [N_SRC-1:0]         cap_valid,
  output logic                     frame_done
);

  localparam int unsigned      SW  = $clog2(N_SRC);
  localparam int unsigned      CW  = $clog2(DWELL);
  localparam logic [N_SRC-1:0] OFF = ALL_OFF[N_SRC-1:0];

  scan_state_t      state_q, state_d;
  logic [SW-1:0]    slot_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             capture;
  logic [N_SRC-1:0] oe_d;

  always_comb begin
    state_d = state_q;
    slot_d  = slot;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = ENABLE;
          slot_d  = '0;
          cnt_d   = '0;
        end
      end
      ENABLE: begin
        // Abort wins over the final dwell cycle: no capture when en drops.
        if (!en) begin
          state_d = IDLE;
          slot_d  = '0;
          cnt_d   = '0;
        end else if (cnt_q == CW'(DWELL - 1)) begin
          capture = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        cnt_d = '0;
        if (en) begin
          state_d = ENABLE;
          slot_d  = (slot == SW'(N_SRC - 1)) ? '0 : slot + SW'(1);
        end else begin
          state_d = IDLE;
          slot_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Decode from next-state values so oe_n comes straight off a flop.
  seg_slot_decoder #(
    .N_SRC (N_SRC),
    .SW    (SW)
  ) u_dec (
    .slot   (slot_d),
    .active (state_d == ENABLE),
    .oe_n   (oe_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      slot       <= '0;
      cnt_q      <= '0;
      oe_n       <= OFF;
      cap_data   <= '0;
      cap_valid  <= '0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot       <= slot_d;
      cnt_q      <= cnt_d;
      oe_n       <= oe_d;
      cap_valid  <= '0;
      frame_done <= 1'b0;
      if (capture) begin
        cap_data[int'(slot)*W +: W] <= bus_in;
        cap_valid[slot]             <= 1'b1;
        frame_done                  <= (slot == SW'(N_SRC - 1));
      end
    end
  end

endmodule

// File: tb/tb_seg_bus_scanner.sv
// Randomized bench for seg_bus_scanner against a time-arithmetic reference model.
module tb_seg_bus_scanner;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 7;
  localparam int unsigned DWELL = 3;
  localparam int unsigned SP    = DWELL + 1;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [W-1:0]     bus_in;
  logic [N-1:0]     oe_n;
  logic [1:0]       slot;
  logic [N*W-1:0]   cap_data;
  logic [N-1:0]     cap_valid;
  logic             frame_done;

  logic [W-1:0]     srcv [N];

  int n_checks = 0;
  int n_pass   = 0;

  // Model: run active flag and cycle index t (1-based) since the run started.
  bit               active = 0;
  int unsigned      t = 0;
  logic [W-1:0]     mcap [N];
  logic [N-1:0]     prev_oe = '1;

  seg_bus_scanner #(.N_SRC(N), .W(W), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus_in     (bus_in),
    .oe_n       (oe_n),
    .slot       (slot),
    .cap_data   (cap_data),
    .cap_valid  (cap_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source buffers: a source drives only while its enable is low.
  always_comb begin
    bus_in = 'z;
    for (int i = 0; i < N; i++) if (!oe_n[i]) bus_in = srcv[i];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    active  = 0;
    t       = 0;
    prev_oe = '1;
    for (int i = 0; i < N; i++) mcap[i] = '0;
  endtask

  task automatic check_outputs();
    int unsigned  pos, s;
    logic [N-1:0] e_oe, e_cv;
    logic [1:0]   e_slot;
    logic         e_fd;
    logic [N*W-1:0] e_cap;
    e_oe = '1; e_cv = '0; e_slot = '0; e_fd = 1'b0;
    if (active) begin
      pos    = (t - 1) % SP;
      s      = ((t - 1) / SP) % N;
      e_slot = 2'(s);
      if (pos < DWELL) e_oe[s] = 1'b0;
      if (pos == DWELL) begin
        e_cv[s] = 1'b1;
        e_fd    = (s == N - 1);
      end
    end
    for (int i = 0; i < N; i++) e_cap[i*W +: W] = mcap[i];
    chk("oe_n", 64'(oe_n), 64'(e_oe));
    chk("slot", 64'(slot), 64'(e_slot));
    chk("cap_valid", 64'(cap_valid), 64'(e_cv));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("cap_data", 64'(cap_data), 64'(e_cap));
    chk("oe_onehot", 64'($countones(~oe_n) <= 1), 64'(1));
    chk("break_before_make",
        64'((prev_oe == '1) || (oe_n == '1) || (prev_oe == oe_n)), 64'(1));
    prev_oe = oe_n;
  endtask

  task automatic step();
    int unsigned pos, s;
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!active) begin
      if (en) begin active = 1; t = 1; end
    end else if (!en) active = 0;
    else t++;
    if (active) begin
      pos = (t - 1) % SP;
      s   = ((t - 1) / SP) % N;
      if (pos == DWELL) mcap[s] = srcv[s];
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int unsigned guard;
    srcv[0] = 7'h3F; srcv[1] = 7'h06; srcv[2] = 7'h5B; srcv[3] = 7'h4F;
    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;

    // Held reset with en high: nothing may move.
    repeat (5) step();
    rst_n = 1'b1;

    // One full frame from cycle 1 to the frame_done cycle 16.
    repeat (16) step();
    chk("frame_slice0", 64'(cap_data[0 +: W]), 64'(7'h3F));
    chk("frame_slice3", 64'(cap_data[3*W +: W]), 64'(7'h4F));

    // Wrap: slice 0 refreshes with a new source value.
    srcv[0] = 7'h66;
    repeat (4) step();
    chk("wrap_slice0", 64'(cap_data[0 +: W]), 64'(7'h66));

    // Abort during slot 2, dwell cycle 1.
    guard = 0;
    while (!(active && ((t - 1) % SP) == 1 && (((t - 1) / SP) % N) == 2) && guard < 100) begin
      step();
      guard++;
    end
    chk("abort_reached", 64'(guard < 100), 64'(1));
    en = 1'b0;
    step();
    chk("abort_oe", 64'(oe_n), 64'(4'hF));
    chk("abort_slice2", 64'(cap_data[2*W +: W]), 64'(7'h5B));
    repeat (3) step();

    // Randomized scan with occasional en drops and source changes.
    en = 1'b1;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) srcv[$urandom_range(0, N - 1)] = W'($urandom);
      step();
      if (c == 300) begin
        // Async reset between edges while a source is enabled.
        en    = 1'b1;
        guard = 0;
        while (!(active && ((t - 1) % SP) < DWELL) && guard < 100) begin
          step();
          guard++;
        end
        chk("async_reached", 64'(guard < 100), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe", 64'(oe_n), 64'(4'hF));
        chk("async_cap", 64'(cap_data), 64'(0));
        chk("async_cv", 64'(cap_valid), 64'(0));
        model_reset();
        #1 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
